// File: rtl/disp_bcd_scan_pkg.sv
// ============================================================================
// Module : disp_pkg
// Brief  : Shared types and constants for the BCD display scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [13:0] BCD_MAX    = 14'd9999;
    localparam logic [3:0]  CONV_ITERS = 4'd14;

    // Double-dabble correction step applied before every shift.
    function automatic logic [15:0] dd_add3(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (res[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/disp_bcd_scan_if.sv
// ============================================================================
// Module : disp_bcd_scan_if
// Brief  : Load channel and display outputs of the BCD display scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface disp_bcd_scan_if;
    logic [13:0] value;
    logic        value_valid;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_select;

    modport master (
        output value, value_valid,
        input  busy, seg, an, digit_select
    );

    modport slave (
        input  value, value_valid,
        output busy, seg, an, digit_select
    );
endinterface

`default_nettype wire

// File: rtl/disp_bcd_scan_seg7_decode.sv
// ============================================================================
// Module : seg7_decode
// Brief  : Active-low 7-segment decoder for one BCD nibble with blank input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_bcd_scan.sv
// ============================================================================
// Module : disp_bcd_scan
// Brief  : Binary-to-BCD converter feeding a 4-digit multiplexed 7-seg scan.
//          Define DISP_LZB_EN to blank leading zero digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module disp_bcd_scan
    import disp_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic           clk,
    input  logic           rst_n,
    disp_bcd_scan_if.slave bus
);

    conv_state_e state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] scratch_q, scratch_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  dsel_q, dsel_d;

    logic [15:0] w_add3;
    logic [3:0]  w_nibble;
    logic        w_blank;
    logic [6:0]  w_seg;

    assign w_add3 = dd_add3(scratch_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            disp_q    <= '0;
            presc_q   <= '0;
            dsel_q    <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            disp_q    <= disp_d;
            presc_q   <= presc_d;
            dsel_q    <= dsel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        disp_d    = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.value_valid) begin
                    bin_d     = (bus.value > BCD_MAX) ? BCD_MAX : bus.value;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                // MSB of the remaining binary shifts into the BCD LSB
                scratch_d = {w_add3[14:0], bin_q[13]};
                bin_d     = {bin_q[12:0], 1'b0};
                iter_d    = iter_q + 4'd1;
                if (iter_q == CONV_ITERS - 4'd1) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d  = scratch_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 16'd1;
        dsel_d  = dsel_q;
        if (presc_q >= SCAN_DIV - 16'd1) begin
            presc_d = '0;
            dsel_d  = dsel_q + 2'd1;
        end
    end

    always_comb begin
        w_nibble = disp_q[3:0];
        w_blank  = 1'b0;
        case (dsel_q)
            2'd0: w_nibble = disp_q[3:0];
            2'd1: w_nibble = disp_q[7:4];
            2'd2: w_nibble = disp_q[11:8];
            2'd3: w_nibble = disp_q[15:12];
            default: w_nibble = disp_q[3:0];
        endcase
`ifdef DISP_LZB_EN
        // A digit is blank only when it and every digit above it are zero.
        case (dsel_q)
            2'd1: w_blank = (disp_q[15:4] == 12'd0);
            2'd2: w_blank = (disp_q[15:8] == 8'd0);
            2'd3: w_blank = (disp_q[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    seg7_decode u_seg7_decode (
        .nibble (w_nibble),
        .blank  (w_blank),
        .seg    (w_seg)
    );

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.seg          = w_seg;
    assign bus.an           = ~(4'b0001 << dsel_q);
    assign bus.digit_select = dsel_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_bcd_scan.sv
// ============================================================================
// Module : tb_disp_bcd_scan
// Brief  : Directed self-checking bench for disp_bcd_scan with SCAN_DIV=4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_disp_bcd_scan;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
    localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SB = 7'h7F;

`ifdef DISP_LZB_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    disp_bcd_scan_if bus ();

    disp_bcd_scan #(.SCAN_DIV(16'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [13:0] v);
        bus.value       = v;
        bus.value_valid = 1'b1;
        step();
        bus.value_valid = 1'b0;
    endtask

    // Busy must stay high for exactly 15 cycles after the load edge.
    task automatic wait_conv(input string tag);
        for (int i = 0; i < 15; i++) begin
            chk({tag, "_busy_hi"}, {15'd0, bus.busy}, 16'd1);
            step();
        end
        chk({tag, "_busy_lo"}, {15'd0, bus.busy}, 16'd0);
    endtask

    task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] e [4];
        logic [3:0] an_exp [4];
        int cyc;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101;
        an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (bus.digit_select !== k[1:0] && cyc < 20) begin
                step();
                cyc++;
            end
            chk({tag, "_dsel"}, {14'd0, bus.digit_select}, k[15:0]);
            chk({tag, "_an"}, {12'd0, bus.an}, {12'd0, an_exp[k]});
            chk({tag, "_seg"}, {9'd0, bus.seg}, {9'd0, e[k]});
        end
    endtask

    initial begin
        logic [3:0] scan_exp [5];
        int cyc;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.value       = '0;
        bus.value_valid = 1'b0;
        scan_exp[0] = 4'b1110; scan_exp[1] = 4'b1101; scan_exp[2] = 4'b1011;
        scan_exp[3] = 4'b0111; scan_exp[4] = 4'b1110;

        // Reset state
        step();
        step();
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_an", {12'd0, bus.an}, 16'h000E);
        chk("rst_seg", {9'd0, bus.seg}, 16'h0040);
        chk("rst_dsel", {14'd0, bus.digit_select}, 16'd0);

        // Scan rotation every 4 cycles
        rst_n = 1'b1;
        chk("scan0", {12'd0, bus.an}, {12'd0, scan_exp[0]});
        for (int s = 1; s < 5; s++) begin
            repeat (3) step();
            chk("scan_hold", {12'd0, bus.an}, {12'd0, scan_exp[s-1]});
            step();
            chk("scan_step", {12'd0, bus.an}, {12'd0, scan_exp[s]});
        end

        check_display("init", LZ, LZ, LZ, S0);

        strobe(14'd1234);
        wait_conv("v1234");
        check_display("v1234", S1, S2, S3, S4);

        strobe(14'd12000);
        wait_conv("v12000");
        check_display("v12000", S9, S9, S9, S9);

        // Second strobe during conversion must be dropped
        strobe(14'd567);
        step();
        step();
        bus.value       = 14'd42;
        bus.value_valid = 1'b1;
        step();
        bus.value_valid = 1'b0;
        chk("v567_busy_mid", {15'd0, bus.busy}, 16'd1);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("v567_done", {15'd0, bus.busy}, 16'd0);
        repeat (5) step();
        chk("v567_idle", {15'd0, bus.busy}, 16'd0);
        check_display("v567", LZ, S5, S6, S7);

        // Reset in the middle of a conversion
        strobe(14'd8888);
        repeat (7) step();
        chk("abort_busy_pre", {15'd0, bus.busy}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {15'd0, bus.busy}, 16'd0);
        chk("abort_an", {12'd0, bus.an}, 16'h000E);
        chk("abort_seg", {9'd0, bus.seg}, 16'h0040);
        step();
        rst_n = 1'b1;
        check_display("abort", LZ, LZ, LZ, S0);

        strobe(14'd8888);
        wait_conv("v8888");
        check_display("v8888", S8, S8, S8, S8);

        strobe(14'd0);
        wait_conv("v0");
        check_display("v0", LZ, LZ, LZ, S0);

        strobe(14'd9999);
        wait_conv("v9999");
        check_display("v9999", S9, S9, S9, S9);

        strobe(14'd305);
        wait_conv("v305");
        check_display("v305", LZ, S3, S0, S5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
